// File: rtl/flash_sequencer.sv
// flash_sequencer: run controller for the bounce-flash LED datapath.
//
// Paces the flash datapath with a prescaled step enable, drives its flick
// input, and counts completed flash runs by watching its state output.
// A host requests run_cnt back-to-back runs with start, may abort with stop
// (the current run drains first), and gets a one-cycle done pulse at the end.
//
// Optional feature: define WATCHDOG_EN to add a per-run step watchdog.
// After WDOG_TICKS steps without finishing a run, it forces the end of the
// sequence and raises a sticky fault. Without the macro, fault is tied to 0.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   start       one-cycle command: begin a sequence of run_cnt runs
//   stop        one-cycle command: abort after the current run drains
//   run_cnt     number of runs, sampled on an accepted start
//   hold        level; while in RUN it drives flick so the flash bounces back
//   flash_state state output of the flash datapath (0 = S0 idle)
//   step_en     one-cycle step enable for the flash datapath
//   flick       flick input to the flash datapath
//   busy        high in every state except IDLE
//   done        one-cycle pulse when a sequence ends
//   aborted     last sequence ended via stop (or watchdog); held until next start
//   runs_left   runs still to complete, including the current one
//   fault       sticky watchdog fault
module flash_sequencer #(
  parameter int TICK_DIV   = 4,
  parameter int DIV_W      = 16,
  parameter int WDOG_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] run_cnt,
  input  logic       hold,
  input  logic [3:0] flash_state,
  output logic       step_en,
  output logic       flick,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] runs_left,
  output logic       fault
);

  if (TICK_DIV < 2 || TICK_DIV > 65535 || WDOG_TICKS < 2) begin : g_bad_param
    $error("flash_sequencer: TICK_DIV or WDOG_TICKS out of range");
  end

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       prev_state;
  logic [3:0]       runs_left_d;
  logic             aborted_d;
  logic             at_s0_step;
  logic             completion;
  logic             wdog_trip;

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign step_en    = busy && (div_cnt == DIV_MAX);
  // A step taken while the datapath sits in S0: either it is about to leave
  // S0 (ARM) or it has just come back to it.
  assign at_s0_step = step_en && (flash_state == 4'd0);
  // A run is complete when a step sees S0 after a step that did not.
  assign completion = at_s0_step && (prev_state != 4'd0);

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_TICKS + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            in_seq;

  assign in_seq    = (state == ARM) || (state == RUN) || (state == DRAIN);
  assign wdog_trip = in_seq && step_en && (wdog_cnt == WD_W'(WDOG_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      // Each new run gets a fresh step budget.
      if (state_d == ARM && state != ARM)
        wdog_cnt <= '0;
      else if (in_seq && step_en)
        wdog_cnt <= wdog_cnt + WD_W'(1);
      if (wdog_trip)
        fault <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign fault     = 1'b0;
`endif

  // Next-state and output decode.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state;
    runs_left_d = runs_left;
    aborted_d   = aborted;
    flick       = 1'b0;
    case (state)
      IDLE: begin
        if (start && run_cnt != 4'd0) begin
          state_d     = ARM;
          runs_left_d = run_cnt;
          aborted_d   = 1'b0;
        end
      end
      ARM: begin
        flick = 1'b1;
        if (wdog_trip) begin
          state_d = DONE; aborted_d = 1'b1; runs_left_d = 4'd0;
        end else if (stop) begin
          aborted_d = 1'b1;
          // If the datapath is leaving S0 on this step, or is already out
          // of it, the run must drain; otherwise nothing is in flight.
          if (at_s0_step || flash_state != 4'd0) begin
            state_d = DRAIN;
          end else begin
            state_d = DONE; runs_left_d = 4'd0;
          end
        end else if (at_s0_step) begin
          state_d = RUN;
        end
      end
      RUN: begin
        flick = hold;
        if (wdog_trip) begin
          state_d = DONE; aborted_d = 1'b1; runs_left_d = 4'd0;
        end else if (stop) begin
          aborted_d = 1'b1;
          if (completion) begin
            state_d = DONE; runs_left_d = 4'd0;
          end else begin
            state_d = DRAIN;
          end
        end else if (completion) begin
          if (runs_left <= 4'd1) begin
            state_d = DONE; runs_left_d = 4'd0;
          end else begin
            state_d = ARM; runs_left_d = runs_left - 4'd1;
          end
        end
      end
      DRAIN: begin
        if (wdog_trip) begin
          state_d = DONE; aborted_d = 1'b1; runs_left_d = 4'd0;
        end else if (at_s0_step) begin
          state_d = DONE; runs_left_d = 4'd0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      prev_state <= 4'd0;
      runs_left  <= 4'd0;
      aborted    <= 1'b0;
    end else begin
      state     <= state_d;
      runs_left <= runs_left_d;
      aborted   <= aborted_d;
      // Held at 0 in IDLE so the first step lands TICK_DIV cycles into ARM.
      div_cnt   <= (!busy || step_en) ? '0 : div_cnt + DIV_W'(1);
      if (step_en)
        prev_state <= flash_state;
    end
  end

endmodule
